// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_scheduler
// Description : Round-robin transmit scheduler for the Duplex UART driver.
//               Arbitrates between two frame sources (ch0 telemetry, ch1
//               command responses). It latches one whole frame, then issues
//               the bytes one at a time on the driver's send/data inputs. Each
//               byte is paced by the driver's tx_done_flag pulse.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk         in   1          system clock
//   rst_n       in   1          asynchronous active-low reset
//   req0/req1   in   1          frame request, held high until the matching ack
//   len0/len1   in   LEN_W      frame length in bytes (clamped to MAX_LEN)
//   frame0/1    in   8*MAX_LEN  frame bytes, byte k at [8k+7:8k], k=0 sent first
//   ack0/ack1   out  1          one-cycle pulse: frame latched
//   uart_send   out  1          one-cycle pulse to the driver's send input
//   uart_data   out  8          byte to the driver's data_transmit input
//   uart_done   in   1          driver's tx_done_flag
//   busy        out  1          high in every state except IDLE
//   frame_done  out  1          one-cycle pulse: last byte of a frame completed
//   frame_ch    out  1          channel of the current or last granted frame
//   err         out  1          one-cycle pulse: byte watchdog abort
// ----------------------------------------------------------------------------
// Build option
//   UART_SCHED_TIMEOUT_EN : when defined, a per-byte watchdog of
//   TIMEOUT_CYCLES cycles abandons a frame whose tx_done_flag never arrives.
//   When undefined, err is tied low and no counter is built.
// ============================================================================
module uart_tx_scheduler #(
  parameter int MAX_LEN        = 8,
  parameter int LEN_W          = 4,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic [LEN_W-1:0]     len0,
  input  logic [8*MAX_LEN-1:0] frame0,
  output logic                 ack0,
  input  logic                 req1,
  input  logic [LEN_W-1:0]     len1,
  input  logic [8*MAX_LEN-1:0] frame1,
  output logic                 ack1,
  output logic                 uart_send,
  output logic [7:0]           uart_data,
  input  logic                 uart_done,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 frame_ch,
  output logic                 err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    GAP  = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] C_MAX_LEN = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] C_ONE     = LEN_W'(1);

  // Elaboration-time sanity check on the configuration.
  generate
    if ((LEN_W != $clog2(MAX_LEN + 1)) || (TIMEOUT_CYCLES < 1)) begin : g_bad_param
      $error("uart_tx_scheduler: LEN_W must equal clog2(MAX_LEN+1) and TIMEOUT_CYCLES must be positive");
    end
  endgenerate

  state_t               r_state;
  logic                 r_last;       // channel granted most recently
  logic [LEN_W-1:0]     r_remaining;  // bytes left including the one in flight
  logic [8*MAX_LEN-1:0] r_buffer;     // byte in flight always sits in [7:0]

  logic                 w_any_req;
  logic                 w_grant;
  logic [LEN_W-1:0]     w_len_sel;
  logic [LEN_W-1:0]     w_len_clamped;
  logic [8*MAX_LEN-1:0] w_frame_sel;
  logic [8*MAX_LEN-1:0] w_buffer_next;

  // Grant selection: a lone requester always wins. When both request, the
  // channel that was not served last wins.
  always_comb begin
    w_any_req = req0 | req1;
    if (req0 && req1) begin
      w_grant = ~r_last;
    end else begin
      w_grant = req1;
    end
    w_len_sel     = w_grant ? len1 : len0;
    w_frame_sel   = w_grant ? frame1 : frame0;
    w_len_clamped = (w_len_sel > C_MAX_LEN) ? C_MAX_LEN : w_len_sel;
    // The buffer is shifted down one byte per advance, so the next byte to
    // send is always the low byte of the shifted value.
    w_buffer_next = r_buffer >> 8;
  end

`ifdef UART_SCHED_TIMEOUT_EN
  localparam int             WD_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] C_WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] C_WD_ONE  = WD_W'(1);

  logic [WD_W-1:0] r_wd_cnt;
  logic            w_wd_expired;

  // The counter is 0 in the first WAIT cycle. Flagging at TIMEOUT_CYCLES-1
  // makes the registered err land exactly TIMEOUT_CYCLES after WAIT entry.
  assign w_wd_expired = (r_wd_cnt == C_WD_LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_remaining <= '0;
      r_buffer    <= '0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      uart_send   <= 1'b0;
      uart_data   <= 8'h00;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frame_ch    <= 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
      err         <= 1'b0;
      r_wd_cnt    <= '0;
`endif
    end else begin
      // Pulse outputs default low and are raised for a single cycle below.
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      uart_send  <= 1'b0;
      frame_done <= 1'b0;
`ifdef UART_SCHED_TIMEOUT_EN
      err        <= 1'b0;
`endif

      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            ack0        <= ~w_grant;
            ack1        <= w_grant;
            frame_ch    <= w_grant;
            r_last      <= w_grant;
            busy        <= 1'b1;
            r_buffer    <= w_frame_sel;
            r_remaining <= w_len_clamped;
            if (w_len_clamped == '0) begin
              // Empty frame: acknowledge and complete without touching the UART.
              frame_done <= 1'b1;
              r_state    <= GAP;
            end else begin
              // Byte 0 goes out in the same cycle as the ack.
              uart_send <= 1'b1;
              uart_data <= w_frame_sel[7:0];
              r_state   <= SEND;
            end
          end
        end

        SEND: begin
          // uart_done is not looked at here; a pulse in this cycle is dropped.
`ifdef UART_SCHED_TIMEOUT_EN
          r_wd_cnt <= '0;
`endif
          r_state <= WAIT;
        end

        WAIT: begin
          if (uart_done) begin
            if (r_remaining == C_ONE) begin
              frame_done <= 1'b1;
              r_state    <= GAP;
            end else begin
              r_remaining <= r_remaining - C_ONE;
              r_buffer    <= w_buffer_next;
              uart_data   <= w_buffer_next[7:0];
              uart_send   <= 1'b1;
              r_state     <= SEND;
            end
          end
`ifdef UART_SCHED_TIMEOUT_EN
          else if (w_wd_expired) begin
            // Abandon the frame: no frame_done for an aborted transfer.
            err     <= 1'b1;
            r_state <= GAP;
          end else begin
            r_wd_cnt <= r_wd_cnt + C_WD_ONE;
          end
`endif
        end

        GAP: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifndef UART_SCHED_TIMEOUT_EN
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire
